// File: rtl/tile_csr_mailbox.sv
// Host<->tile CSR mailbox: a command FIFO feeding csr_in and a response FIFO drained by the host.
// Optional sticky ovf/udf flags are enabled by defining TILE_MAILBOX_STICKY_EN.

module mbox_fifo #(
  parameter int W   = 16,
  parameter int DL2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [DL2:0] level
);
  localparam int DEPTH = 1 << DL2;

  logic [W-1:0]   mem [DEPTH];
  logic [DL2-1:0] wptr, rptr;

  // push/pop arrive pre-qualified against level, so no full/empty guards here
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + DL2'(1);
      if (pop)  rptr <= rptr + DL2'(1);
      case ({push, pop})
        2'b10:   level <= level + (DL2+1)'(1);
        2'b01:   level <= level - (DL2+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= wdata;
  end

  assign head = (level != '0) ? mem[rptr] : '0;
endmodule

module tile_csr_mailbox #(
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int DEPTH_LOG2    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CSR_IN_WIDTH-1:0]  host_cmd_data,
  input  logic                     host_cmd_valid,
  output logic                     host_cmd_ready,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic                     csr_in_re,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  output logic [CSR_OUT_WIDTH-1:0] host_rsp_data,
  output logic                     host_rsp_valid,
  input  logic                     host_rsp_ready,
  output logic [DEPTH_LOG2:0]      cmd_level,
  output logic [DEPTH_LOG2:0]      rsp_level,
  output logic                     ovf_flag,
  output logic                     udf_flag,
  input  logic                     flag_clr
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = DEPTH[DEPTH_LOG2:0];

  logic cmd_push, cmd_pop, rsp_push, rsp_pop, udf_evt, ovf_evt;

  // ready looks only at the registered level; a same-cycle pop does not help
  assign host_cmd_ready = !rst && (cmd_level != FULL);
  assign cmd_push       = host_cmd_valid && host_cmd_ready;
  assign cmd_pop        = csr_in_re && (cmd_level != '0);
  assign udf_evt        = csr_in_re && (cmd_level == '0);

  assign host_rsp_valid = (rsp_level != '0);
  assign rsp_pop        = host_rsp_valid && host_rsp_ready;
  // a full response FIFO still takes a word when the host frees a slot this cycle
  assign rsp_push       = csr_out_we && ((rsp_level != FULL) || rsp_pop);
  assign ovf_evt        = csr_out_we && !rsp_push;

  mbox_fifo #(.W(CSR_IN_WIDTH), .DL2(DEPTH_LOG2)) u_cmd (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .wdata (host_cmd_data),
    .head  (csr_in),
    .level (cmd_level)
  );

  mbox_fifo #(.W(CSR_OUT_WIDTH), .DL2(DEPTH_LOG2)) u_rsp (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .pop   (rsp_pop),
    .wdata (csr_out),
    .head  (host_rsp_data),
    .level (rsp_level)
  );

`ifdef TILE_MAILBOX_STICKY_EN
  // a set event outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
    end else begin
      if (ovf_evt)       ovf_flag <= 1'b1;
      else if (flag_clr) ovf_flag <= 1'b0;
      if (udf_evt)       udf_flag <= 1'b1;
      else if (flag_clr) udf_flag <= 1'b0;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{flag_clr, ovf_evt, udf_evt};
  assign ovf_flag     = 1'b0;
  assign udf_flag     = 1'b0;
`endif
endmodule

// File: tb/tb_tile_csr_mailbox.sv
// Scoreboard bench for tile_csr_mailbox at default parameters (depth 4).
module tb_tile_csr_mailbox;
`ifdef TILE_MAILBOX_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] host_cmd_data;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic [15:0] csr_in;
  logic        csr_in_re;
  logic [15:0] csr_out;
  logic        csr_out_we;
  logic [15:0] host_rsp_data;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [2:0]  cmd_level;
  logic [2:0]  rsp_level;
  logic        ovf_flag;
  logic        udf_flag;
  logic        flag_clr;

  tile_csr_mailbox dut (
    .clk(clk), .rst(rst),
    .host_cmd_data(host_cmd_data), .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .csr_in(csr_in), .csr_in_re(csr_in_re),
    .csr_out(csr_out), .csr_out_we(csr_out_we),
    .host_rsp_data(host_rsp_data), .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .cmd_level(cmd_level), .rsp_level(rsp_level),
    .ovf_flag(ovf_flag), .udf_flag(udf_flag), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [15:0] cmd_q[$];
  logic [15:0] rsp_q[$];
  bit ovf_m, udf_m;

  function automatic logic [15:0] cmd_head();
    return (cmd_q.size() != 0) ? cmd_q[0] : 16'h0;
  endfunction
  function automatic logic [15:0] rsp_head();
    return (rsp_q.size() != 0) ? rsp_q[0] : 16'h0;
  endfunction

  // advance the reference model with the inputs currently driven, then clock once
  task automatic cycle();
    bit cpush, cpop, rpush, rpop;
    cpush = host_cmd_valid && !rst && (cmd_q.size() != D);
    cpop  = csr_in_re && (cmd_q.size() != 0);
    rpop  = host_rsp_ready && (rsp_q.size() != 0);
    rpush = csr_out_we && ((rsp_q.size() != D) || rpop);
    if (rst) begin
      cmd_q.delete(); rsp_q.delete(); ovf_m = 0; udf_m = 0;
    end else begin
      if (cpop)  void'(cmd_q.pop_front());
      if (cpush) cmd_q.push_back(host_cmd_data);
      if (rpop)  void'(rsp_q.pop_front());
      if (rpush) rsp_q.push_back(csr_out);
      if (csr_in_re && !cpop)       udf_m = 1;
      else if (flag_clr)            udf_m = 0;
      if (csr_out_we && !rpush)     ovf_m = 1;
      else if (flag_clr)            ovf_m = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    host_cmd_valid = 0; csr_in_re = 0; csr_out_we = 0; host_rsp_ready = 0; flag_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); host_cmd_data = 0; csr_out = 0;
    #1;
    nchk++; if (host_cmd_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready_in_rst got=%b exp=0", host_cmd_ready); end
    cycle(); cycle();
    rst = 0; #1;
    nchk++; if ({host_cmd_ready, host_rsp_valid, ovf_flag, udf_flag} !== 4'b1000)
      begin nerr++; $display("FAIL reset_ctrl got=%b exp=1000", {host_cmd_ready, host_rsp_valid, ovf_flag, udf_flag}); end
    nchk++; if ({csr_in, host_rsp_data, cmd_level, rsp_level} !== 38'h0)
      begin nerr++; $display("FAIL reset_data csr_in=%h rsp=%h cl=%0d rl=%0d exp all 0", csr_in, host_rsp_data, cmd_level, rsp_level); end
  endtask

  task automatic test_cmd_basic();
    host_cmd_data = 16'h1234; host_cmd_valid = 1; cycle(); host_cmd_valid = 0;
    nchk++; if (csr_in !== 16'h1234 || cmd_level !== 3'd1)
      begin nerr++; $display("FAIL cmd_basic_push csr_in=%h lvl=%0d exp 1234/1", csr_in, cmd_level); end
    nchk++; if (csr_in !== cmd_head()) begin nerr++; $display("FAIL cmd_basic_pop got=%h exp=%h", csr_in, cmd_head()); end
    csr_in_re = 1; cycle(); csr_in_re = 0;
    nchk++; if (csr_in !== 16'h0 || cmd_level !== 3'd0)
      begin nerr++; $display("FAIL cmd_basic_empty csr_in=%h lvl=%0d exp 0/0", csr_in, cmd_level); end
  endtask

  task automatic test_cmd_full();
    for (int i = 1; i <= 4; i++) begin host_cmd_data = 16'hA000 + 16'(i); host_cmd_valid = 1; cycle(); end
    nchk++; if (host_cmd_ready !== 1'b0 || cmd_level !== 3'd4)
      begin nerr++; $display("FAIL cmd_full ready=%b lvl=%0d exp 0/4", host_cmd_ready, cmd_level); end
    host_cmd_data = 16'hA005; csr_in_re = 1;
    for (int i = 0; i < 7; i++) begin
      nchk++; if (csr_in !== cmd_head()) begin nerr++; $display("FAIL cmd_drain[%0d] got=%h exp=%h", i, csr_in, cmd_head()); end
      cycle(); host_cmd_valid = 0;
    end
    csr_in_re = 0;
    nchk++; if (cmd_level !== 3'd0 || udf_flag !== (STICKY & udf_m))
      begin nerr++; $display("FAIL cmd_udf lvl=%0d udf=%b exp 0/%b", cmd_level, udf_flag, STICKY & udf_m); end
    flag_clr = 1; cycle(); flag_clr = 0;
    nchk++; if (udf_flag !== 1'b0) begin nerr++; $display("FAIL udf_clear got=%b exp=0", udf_flag); end
  endtask

  task automatic test_rsp_ovf();
    host_rsp_ready = 0;
    for (int i = 1; i <= 5; i++) begin csr_out = 16'hB000 + 16'(i); csr_out_we = 1; cycle(); end
    csr_out_we = 0;
    nchk++; if (rsp_level !== 3'd4 || ovf_flag !== (STICKY & ovf_m) || host_rsp_data !== 16'hB001 || host_rsp_valid !== 1'b1)
      begin nerr++; $display("FAIL rsp_ovf lvl=%0d ovf=%b data=%h v=%b exp 4/%b/b001/1", rsp_level, ovf_flag, host_rsp_data, host_rsp_valid, STICKY & ovf_m); end
    host_rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      nchk++; if (host_rsp_valid !== (rsp_q.size() != 0) || host_rsp_data !== rsp_head())
        begin nerr++; $display("FAIL rsp_drain[%0d] v=%b data=%h exp %b/%h", i, host_rsp_valid, host_rsp_data, rsp_q.size() != 0, rsp_head()); end
      cycle();
    end
    host_rsp_ready = 0; flag_clr = 1; cycle(); flag_clr = 0;
    nchk++; if (ovf_flag !== 1'b0 || rsp_level !== 3'd0)
      begin nerr++; $display("FAIL ovf_clear ovf=%b lvl=%0d exp 0/0", ovf_flag, rsp_level); end
  endtask

  task automatic test_rsp_bypass();
    for (int i = 1; i <= 4; i++) begin csr_out = 16'hC000 + 16'(i); csr_out_we = 1; cycle(); end
    csr_out = 16'hC0DE; host_rsp_ready = 1;
    nchk++; if (host_rsp_data !== rsp_head()) begin nerr++; $display("FAIL bypass_head got=%h exp=%h", host_rsp_data, rsp_head()); end
    cycle(); csr_out_we = 0; host_rsp_ready = 0;
    nchk++; if (rsp_level !== 3'd4 || ovf_flag !== 1'b0)
      begin nerr++; $display("FAIL bypass_full lvl=%0d ovf=%b exp 4/0", rsp_level, ovf_flag); end
    host_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      nchk++; if (host_rsp_data !== rsp_head()) begin nerr++; $display("FAIL bypass_drain[%0d] got=%h exp=%h", i, host_rsp_data, rsp_head()); end
      if (i == 3) begin
        nchk++; if (host_rsp_data !== 16'hC0DE) begin nerr++; $display("FAIL bypass_last got=%h exp=c0de", host_rsp_data); end
      end
      cycle();
    end
    host_rsp_ready = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      host_cmd_data = 16'hD100 + 16'(i); host_cmd_valid = 1; csr_out = 16'hE100 + 16'(i); csr_out_we = 1; cycle();
    end
    for (int i = 0; i < 20; i++) begin
      host_cmd_data = 16'hD000 + 16'(i); csr_out = 16'hE000 + 16'(i);
      host_cmd_valid = 1; csr_in_re = 1; csr_out_we = 1; host_rsp_ready = 1;
      nchk++; if (csr_in !== cmd_head() || host_rsp_data !== rsp_head())
        begin nerr++; $display("FAIL b2b_data[%0d] cmd=%h/%h rsp=%h/%h", i, csr_in, cmd_head(), host_rsp_data, rsp_head()); end
      cycle();
      nchk++; if (cmd_level !== 3'd3 || rsp_level !== 3'd3)
        begin nerr++; $display("FAIL b2b_level[%0d] cl=%0d rl=%0d exp 3/3", i, cmd_level, rsp_level); end
    end
    idle_inputs();
    nchk++; if (ovf_flag !== 1'b0 || udf_flag !== 1'b0)
      begin nerr++; $display("FAIL b2b_flags ovf=%b udf=%b exp 0/0", ovf_flag, udf_flag); end
  endtask

  task automatic test_mid_reset();
    // FIFOs hold 3 each from the previous scenario; trim to half full
    csr_in_re = 1; host_rsp_ready = 1; cycle(); idle_inputs();
    nchk++; if (cmd_level !== 3'd2 || rsp_level !== 3'd2)
      begin nerr++; $display("FAIL half_full cl=%0d rl=%0d exp 2/2", cmd_level, rsp_level); end
    rst = 1; host_cmd_valid = 1; csr_out_we = 1; csr_in_re = 1; host_rsp_ready = 1;
    cycle(); rst = 0; idle_inputs(); #1;
    nchk++; if ({host_cmd_ready, host_rsp_valid, ovf_flag, udf_flag} !== 4'b1000 || {csr_in, host_rsp_data, cmd_level, rsp_level} !== 38'h0)
      begin nerr++; $display("FAIL midrst_state rdy=%b v=%b csr_in=%h rsp=%h cl=%0d rl=%0d", host_cmd_ready, host_rsp_valid, csr_in, host_rsp_data, cmd_level, rsp_level); end
    csr_in_re = 1; host_rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      nchk++; if (csr_in !== 16'h0 || host_rsp_valid !== 1'b0)
        begin nerr++; $display("FAIL midrst_drain[%0d] csr_in=%h v=%b exp 0/0", i, csr_in, host_rsp_valid); end
      cycle();
    end
    flag_clr = 1; cycle(); idle_inputs();
    nchk++; if (udf_flag !== (STICKY & udf_m))
      begin nerr++; $display("FAIL clr_vs_set udf=%b exp=%b", udf_flag, STICKY & udf_m); end
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_cmd_full();
    test_rsp_ovf();
    test_rsp_bypass();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
